// File: rtl/vga_frame_pkg.sv
// Shared constants, FSM encoding and pixel->word mapping for the 800x480 1bpp frame buffer.
// Reader and writer both use pix_to_loc so their address/bit mapping can never diverge.
package vga_frame_pkg;
  localparam int H_ACTIVE    = 800;
  localparam int V_ACTIVE    = 480;
  localparam int WORD_W      = 16;
  localparam int ADDR_W      = 16;
  localparam int BIT_W       = $clog2(WORD_W);
  localparam int COORD_W     = 11;
  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CALC, ST_READ, ST_WAIT, ST_WRITE, ST_CLEAR
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BIT_W-1:0]  bidx;
  } pix_loc_t;

  function automatic pix_loc_t pix_to_loc(input logic [COORD_W-1:0] x,
                                          input logic [COORD_W-1:0] y);
    logic [31:0] pn;
    pix_loc_t    loc;
    pn       = 32'(y) * 32'(H_ACTIVE) + 32'(x);
    loc.addr = ADDR_W'(pn >> BIT_W);
    loc.bidx = pn[BIT_W-1:0];
    return loc;
  endfunction
endpackage

// File: rtl/vga_pixel_addr.sv
// Combinational x,y -> RAM word address and bit index.
module vga_pixel_addr
  import vga_frame_pkg::*;
(
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [BIT_W-1:0]   bidx_o
);
  pix_loc_t loc;

  assign loc    = pix_to_loc(x_i, y_i);
  assign addr_o = loc.addr;
  assign bidx_o = loc.bidx;
endmodule

// File: rtl/vga_frame_writer.sv
// Write side of the 1bpp frame buffer: single-pixel read-modify-write and full-frame fill.
// Requests are fully serialised, so repeated writes to one word always see prior results.
module vga_frame_writer
  import vga_frame_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               pix_value,
  input  logic               clear_req,
  input  logic               clear_value,
  output logic               busy,
  output logic               done,
  output logic               range_err,
  output logic [ADDR_W-1:0]  ram_read_address,
  input  logic [WORD_W-1:0]  ram_q,
  output logic [ADDR_W-1:0]  ram_write_address,
  output logic [WORD_W-1:0]  ram_d,
  output logic               ram_we
);
  localparam logic [COORD_W-1:0] H_LIM     = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM     = COORD_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0]  LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

  state_e              state_q;
  logic [COORD_W-1:0]  x_q, y_q;
  logic                val_q;
  logic [BIT_W-1:0]    bidx_q;
  logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
  logic [WORD_W-1:0]   fill_q, merged_d;
  logic                we_q, done_q, rerr_q;
  logic [ADDR_W-1:0]   calc_addr;
  logic [BIT_W-1:0]    calc_bidx;
  logic                in_range;

  vga_pixel_addr u_addr (
    .x_i    (x_q),
    .y_i    (y_q),
    .addr_o (calc_addr),
    .bidx_o (calc_bidx)
  );

  assign in_range = (pix_x < H_LIM) && (pix_y < V_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      val_q     <= 1'b0;
      bidx_q    <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      fill_q    <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rerr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            fill_q    <= {WORD_W{clear_value}};
            wr_addr_q <= '0;
            we_q      <= 1'b1;
            state_q   <= ST_CLEAR;
          end else if (pix_valid) begin
            x_q   <= pix_x;
            y_q   <= pix_y;
            val_q <= pix_value;
            if (in_range) state_q <= ST_CALC;
            else          rerr_q  <= 1'b1;
          end
        end
        ST_CALC: begin
          rd_addr_q <= calc_addr;
          bidx_q    <= calc_bidx;
          state_q   <= ST_READ;
        end
        ST_READ: state_q <= ST_WAIT;
        ST_WAIT: begin
          wr_addr_q <= rd_addr_q;
          we_q      <= 1'b1;
          done_q    <= 1'b1;
          state_q   <= ST_WRITE;
        end
        ST_WRITE: begin
          we_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_CLEAR: begin
          if (wr_addr_q == LAST_WORD) begin
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            wr_addr_q <= wr_addr_q + 1'b1;
          end
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Read data arrives after the WAIT cycle, so the merge is taken straight off ram_q.
  always_comb begin
    merged_d         = ram_q;
    merged_d[bidx_q] = val_q;
  end

  assign ram_d             = (state_q == ST_WRITE) ? merged_d : fill_q;
  assign ram_we            = we_q;
  assign ram_write_address = wr_addr_q;
  assign ram_read_address  = rd_addr_q;
  assign done              = done_q;
  assign range_err         = rerr_q;
  assign busy              = (state_q != ST_IDLE);
  assign pix_ready         = (state_q == ST_IDLE) && !clear_req;
endmodule

// File: doc/vga_frame_writer.md
Name: vga_frame_writer

Overview:
- Write side of the 800x480, 1-bit-per-pixel VGA frame buffer held in 16-bit-word RAM.
- Accepts single-pixel write requests (x, y, value) over a valid/ready handshake.
- Translates each request to word address and bit index, then performs a read-modify-write on the RAM's write-side port.
- Also supports a full-frame fill command; sits between the drawing logic and vga_ram.

Parameters:
- H_ACTIVE, 800, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- WORD_W, 16, RAM word width = pixels per word.
- ADDR_W, 16, RAM address width.
- FRAME_WORDS, H_ACTIVE*V_ACTIVE/WORD_W (24000), words per frame.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pix_valid  in  1  pixel write request
- pix_ready  out  1  request accepted when pix_valid & pix_ready
- pix_x  in  11  horizontal coordinate
- pix_y  in  11  vertical coordinate
- pix_value  in  1  bit to store (1 = white)
- clear_req  in  1  start full-frame fill (sampled in IDLE only)
- clear_value  in  1  fill bit, replicated to all WORD_W bits
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when an operation completes (pixel RMW or clear)
- range_err  out  1  one-cycle pulse when an out-of-range request is dropped
- ram_read_address  out  ADDR_W  RAM read address
- ram_q  in  WORD_W  RAM read data, valid one cycle after address
- ram_write_address  out  ADDR_W  RAM write address
- ram_d  out  WORD_W  RAM write data
- ram_we  out  1  RAM write enable

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0 except pix_ready, which follows its IDLE equation; all address/data registers 0.
- pix_ready = (state==IDLE) & ~clear_req. clear_req beats pix_valid in the same cycle.
- FSM states: IDLE, CALC, READ, WAIT, WRITE, CLEAR.
- IDLE, clear_req=1: latch clear_value, set word counter to 0, go to CLEAR.
- IDLE, pix_valid & pix_ready:
  - Register x, y, value.
  - If x>=H_ACTIVE or y>=V_ACTIVE: pulse range_err next cycle, no RAM write, stay IDLE.
  - Otherwise go to CALC.
- CALC: pixel_number = y*H_ACTIVE + x, computed in 32 bits. Register addr = pixel_number>>4 and bit = pixel_number[3:0]. Go to READ.
- READ: drive ram_read_address=addr. Go to WAIT.
- WAIT: RAM latency cycle. Go to WRITE.
- WRITE:
  - ram_d = ram_q with bit[bit] replaced by value; all other bits unchanged.
  - ram_write_address=addr, ram_we=1 for exactly this cycle.
  - Pulse done; go to IDLE.
- Latency: handshake accepted at cycle T; ram_we at T+4; pix_ready high again at T+5.
- Maximum throughput: one pixel per 5 cycles.
- Word hazards: requests are fully serialised, so back-to-back writes to the same word are always coherent (second RMW reads the first's result).
- CLEAR:
  - ram_we=1 every cycle, ram_write_address = counter, ram_d = {WORD_W{clear_value}}.
  - Counter increments each cycle.
  - After address FRAME_WORDS-1 is written: pulse done, return to IDLE. Exactly 24000 write cycles, no wrap.
  - clear_req and pix_valid are ignored while in CLEAR.
- Reset during any state aborts immediately. ram_we drops asynchronously; a partial clear is not resumed.
- ram_read_address holds its last value outside READ. ram_we=0 in every state except WRITE and CLEAR.

Decomposition:
- Shared package vga_frame_pkg holds:
  - H_ACTIVE, V_ACTIVE, WORD_W, FRAME_WORDS constants.
  - FSM state encoding.
  - The pixel-to-address/bit function, so reader and writer use identical mapping.
- One natural sub-module: vga_pixel_addr, a combinational x,y -> word address/bit index unit, reusable by the display reader.

Test Plan:
- Write (0,0)=1 on zeroed RAM -> ram_read_address 0 at T+2; ram_we at T+4, address 0, ram_d 16'h0001; done at T+4.
- Write (17,1)=1 -> pixel 817, address 51, bit 1, ram_d 16'h0002. Then write (16,1)=1 -> address 51, ram_d 16'h0003 (RMW preserves bit 1).
- Write (799,479)=1 -> pixel 383999, address 23999, bit 15, ram_d 16'h8000. Then write (799,479)=0 -> ram_d 16'h0000.
- Write (800,0) and (0,480) -> range_err pulse each time, ram_we never asserted, pix_ready returns high next cycle.
- clear_req with clear_value=1, pix_valid asserted in the same cycle -> pix_ready 0; 24000 consecutive writes of 16'hFFFF to addresses 0..23999; done after the last; pixel then accepted.
- Assert reset_n=0 mid-clear at address 1000 -> ram_we 0 immediately, busy 0, state IDLE; new clear restarts from address 0.
